// File: rtl/regfile_access_ctrl_if.sv
// Handshake/bus bundle between decode, writeback, the access
// controller and the 8x8 register file.
interface regfile_access_ctrl_if #(
  parameter int WB_DEPTH = 4,
  parameter int AW       = 3,
  parameter int DW       = 8
);
  logic                           rd_req;
  logic [AW-1:0]                  rd_addr1;
  logic [AW-1:0]                  rd_addr2;
  logic                           rd_ready;
  logic                           rd_valid;
  logic [DW-1:0]                  rd_data1;
  logic [DW-1:0]                  rd_data2;
  logic                           wr_req;
  logic [AW-1:0]                  wr_addr;
  logic [DW-1:0]                  wr_data;
  logic                           wr_ready;
  logic [AW-1:0]                  rf_r_addr1;
  logic [AW-1:0]                  rf_r_addr2;
  logic [AW-1:0]                  rf_w_addr;
  logic [DW-1:0]                  rf_w_data;
  logic                           rf_r_or_w;
  logic [DW-1:0]                  rf_data1;
  logic [DW-1:0]                  rf_data2;
  logic [$clog2(WB_DEPTH+1)-1:0]  wb_count;

  modport slave (
    input  rd_req, rd_addr1, rd_addr2,
    input  wr_req, wr_addr, wr_data,
    input  rf_data1, rf_data2,
    output rd_ready, rd_valid, rd_data1, rd_data2,
    output wr_ready,
    output rf_r_addr1, rf_r_addr2,
    output rf_w_addr, rf_w_data, rf_r_or_w,
    output wb_count
  );

  modport master (
    output rd_req, rd_addr1, rd_addr2,
    output wr_req, wr_addr, wr_data,
    output rf_data1, rf_data2,
    input  rd_ready, rd_valid, rd_data1, rd_data2,
    input  wr_ready,
    input  rf_r_addr1, rf_r_addr2,
    input  rf_w_addr, rf_w_data, rf_r_or_w,
    input  wb_count
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Single-port regfile arbiter: buffered writes, bypassed reads,
// fixed 1-cycle operand latency.
module regfile_access_ctrl #(
  parameter int WB_DEPTH = 4,
  parameter int AW       = 3,
  parameter int DW       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_access_ctrl_if.slave   bus
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(WB_DEPTH+1);

  logic [AW-1:0] wb_addr [WB_DEPTH];
  logic [DW-1:0] wb_data [WB_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          full;
  logic          rd_go;
  logic          drain;
  logic          enq;

  logic          hit1_d;
  logic          hit2_d;
  logic [DW-1:0] byp1_d;
  logic [DW-1:0] byp2_d;
  logic          hit1_q;
  logic          hit2_q;
  logic [DW-1:0] byp1_q;
  logic [DW-1:0] byp2_q;
  logic          rd_valid_q;
  logic [PW:0]   slot;

  assign full  = (count == CW'(WB_DEPTH));
  assign rd_go = bus.rd_req && bus.rd_ready;
  assign enq   = bus.wr_req && bus.wr_ready;
  // a full buffer beats reads so writeback can never deadlock
  assign drain = !reset &&
                 (full || (!rd_go && count != '0));

  assign bus.rd_ready   = !reset && !full;
  assign bus.wr_ready   = !reset && !full;
  assign bus.rf_r_or_w  = drain;
  assign bus.rf_r_addr1 = rd_go ? bus.rd_addr1 : '0;
  assign bus.rf_r_addr2 = rd_go ? bus.rd_addr2 : '0;
  assign bus.rf_w_addr  = drain ? wb_addr[head] : '0;
  assign bus.rf_w_data  = drain ? wb_data[head] : '0;
  assign bus.wb_count   = count;

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data1   = !rd_valid_q ? '0 :
                          hit1_q ? byp1_q : bus.rf_data1;
  assign bus.rd_data2   = !rd_valid_q ? '0 :
                          hit2_q ? byp2_q : bus.rf_data2;

  // walk oldest to newest so the newest match overwrites
  always_comb begin
    hit1_d = 1'b0;
    hit2_d = 1'b0;
    byp1_d = '0;
    byp2_d = '0;
    slot   = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot = {1'b0, head} + (PW+1)'(k);
      if (slot >= (PW+1)'(WB_DEPTH))
        slot = slot - (PW+1)'(WB_DEPTH);
      if (CW'(k) < count) begin
        if (wb_addr[slot[PW-1:0]] == bus.rd_addr1) begin
          hit1_d = 1'b1;
          byp1_d = wb_data[slot[PW-1:0]];
        end
        if (wb_addr[slot[PW-1:0]] == bus.rd_addr2) begin
          hit2_d = 1'b1;
          byp2_d = wb_data[slot[PW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rd_valid_q <= 1'b0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      byp1_q     <= '0;
      byp2_q     <= '0;
    end else begin
      if (enq) begin
        wb_addr[tail] <= bus.wr_addr;
        wb_data[tail] <= bus.wr_data;
        tail <= (tail == PW'(WB_DEPTH-1)) ?
                '0 : tail + 1'b1;
      end
      if (drain)
        head <= (head == PW'(WB_DEPTH-1)) ?
                '0 : head + 1'b1;
      count      <= count + CW'(enq) - CW'(drain);
      rd_valid_q <= rd_go;
      if (rd_go) begin
        hit1_q <= hit1_d;
        hit2_q <= hit2_d;
        byp1_q <= byp1_d;
        byp2_q <= byp2_d;
      end
    end
  end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural
// single-port 8x8 register file hanging off the rf_* bus.
module tb_regfile_access_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rf_writes;
  int   wr_snap;
  logic [7:0] rf [8];

  regfile_access_ctrl_if #(
    .WB_DEPTH(4), .AW(3), .DW(8)
  ) bus ();

  regfile_access_ctrl #(
    .WB_DEPTH(4), .AW(3), .DW(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // regfile: one registered read or one write per clock
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else if (bus.rf_r_or_w) begin
      rf[bus.rf_w_addr] <= bus.rf_w_data;
      rf_writes <= rf_writes + 1;
    end else begin
      bus.rf_data1 <= rf[bus.rf_r_addr1];
      bus.rf_data2 <= rf[bus.rf_r_addr2];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a1,
                    input logic [2:0] a2);
    bus.rd_req   = 1'b1;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [7:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rf_writes = 0;
    bus.rf_data1 = 8'h00;
    bus.rf_data2 = 8'h00;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_r_or_w", bus.rf_r_or_w, 0);
    chk("rst_count", bus.wb_count, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data1", bus.rd_data1, 0);
    reset = 1'b0;
    #1;
    chk("rd_ready", bus.rd_ready, 1);

    // single write drains when no reads compete
    wr(3'd3, 8'h5A);
    #1;
    chk("wr_ready", bus.wr_ready, 1);
    step();
    idle();
    #1;
    chk("w1_count", bus.wb_count, 1);
    chk("w1_r_or_w", bus.rf_r_or_w, 1);
    chk("w1_w_addr", bus.rf_w_addr, 3);
    chk("w1_w_data", bus.rf_w_data, 8'h5A);
    step();
    chk("w1_count0", bus.wb_count, 0);
    chk("w1_rf3", rf[3], 8'h5A);

    // preload r5=0x33 through the normal path
    wr(3'd5, 8'h33);
    step();
    idle();
    step();
    chk("pre_rf5", rf[5], 8'h33);

    // bypass of buffered r2 while reads hold the port
    wr(3'd2, 8'h11);
    step();
    bus.wr_req = 1'b0;
    rd(3'd2, 3'd5);
    #1;
    chk("byp_no_drain", bus.rf_r_or_w, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("byp_valid", bus.rd_valid, 1);
      chk("byp_data1", bus.rd_data1, 8'h11);
      chk("byp_data2", bus.rd_data2, 8'h33);
      chk("byp_count", bus.wb_count, 1);
      chk("byp_r_or_w", bus.rf_r_or_w, 0);
    end
    idle();
    step();
    chk("byp_drained", bus.wb_count, 0);
    chk("byp_rf2", rf[2], 8'h11);
    chk("byp_valid0", bus.rd_valid, 0);

    // four writes under continuous reads fill the buffer
    rd(3'd0, 3'd0);
    wr(3'd6, 8'h01);
    step();
    wr(3'd7, 8'h02);
    step();
    wr(3'd6, 8'h03);
    step();
    wr(3'd7, 8'h04);
    step();
    bus.wr_req = 1'b0;
    #1;
    chk("full_count", bus.wb_count, 4);
    chk("full_rd_ready", bus.rd_ready, 0);
    chk("full_wr_ready", bus.wr_ready, 0);
    chk("full_drain", bus.rf_r_or_w, 1);
    chk("full_w_addr", bus.rf_w_addr, 6);
    chk("full_w_data", bus.rf_w_data, 8'h01);
    step();
    chk("full_count3", bus.wb_count, 3);
    chk("full_rd_ready1", bus.rd_ready, 1);
    chk("full_no_rd", bus.rd_valid, 0);
    chk("full_read", bus.rf_r_or_w, 0);
    idle();
    step();
    step();
    step();
    chk("full_empty", bus.wb_count, 0);
    chk("full_rf6", rf[6], 8'h03);
    chk("full_rf7", rf[7], 8'h04);

    // two writes to r1: newest buffered value wins
    rd(3'd0, 3'd0);
    wr(3'd1, 8'hAA);
    step();
    wr(3'd1, 8'hBB);
    step();
    bus.wr_req = 1'b0;
    rd(3'd1, 3'd0);
    step();
    chk("waw_count", bus.wb_count, 2);
    chk("waw_data1", bus.rd_data1, 8'hBB);
    idle();
    step();
    chk("waw_mid_rf1", rf[1], 8'hAA);
    step();
    chk("waw_rf1", rf[1], 8'hBB);
    chk("waw_empty", bus.wb_count, 0);

    // same-cycle read and write: read returns old value
    wr(3'd4, 8'h07);
    step();
    idle();
    step();
    chk("pre_rf4", rf[4], 8'h07);
    rd(3'd4, 3'd4);
    wr(3'd4, 8'h99);
    step();
    idle();
    #1;
    chk("raw_data1", bus.rd_data1, 8'h07);
    chk("raw_data2", bus.rd_data2, 8'h07);
    step();
    chk("raw_empty", bus.wb_count, 0);
    rd(3'd4, 3'd3);
    step();
    idle();
    #1;
    chk("raw_new", bus.rd_data1, 8'h99);
    chk("raw_r3", bus.rd_data2, 8'h5A);

    // reset with three buffered writes discards them
    rd(3'd0, 3'd0);
    wr(3'd1, 8'h21);
    step();
    wr(3'd2, 8'h22);
    step();
    wr(3'd3, 8'h23);
    step();
    chk("pre_rst_count", bus.wb_count, 3);
    idle();
    reset = 1'b1;
    #1;
    chk("mid_rst_r_or_w", bus.rf_r_or_w, 0);
    chk("mid_rst_wr_rdy", bus.wr_ready, 0);
    wr_snap = rf_writes;
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_count", bus.wb_count, 0);
    chk("post_rst_valid", bus.rd_valid, 0);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_r_or_w", bus.rf_r_or_w, 0);
      step();
    end
    chk("post_rst_writes", rf_writes, wr_snap);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
